lsu_unit: RTL and testbench
===========================

# lsu_unit

Load/store unit sitting directly downstream of the core datapath's memory port: takes one load or store request at a time, performs byte/half/word lane steering and alignment checking, drives a synchronous single-port data SRAM with configurable read wait-states, and returns sign- or zero-extended load data. It stalls the datapath while an access is in flight and emits the per-access trace signals (`wr`, `rd`, `addr`, `wr_data`, `rd_data`) consumed by the top-level testbench.

## Interface
Parameters:
- `DATA_W`, 32: data width; only 32 is supported.
- `ADDR_W`, 9: byte-address width.
- `WAIT_CYC`, 1: SRAM latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range is 1..7.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request present. Must be held stable while `stall`=1.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RV32I funct3 (LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5).
- `req_addr`, in, ADDR_W: byte address.
- `req_wdata`, in, DATA_W: store data, right-aligned.
- `stall`, out, 1: freeze the datapath.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, DATA_W: extended load data; 0 for stores.
- `lsu_err`, out, 1: one-cycle pulse for a misaligned or illegal-funct3 request.
- `mem_en`, out, 1: SRAM enable.
- `mem_we`, out, 1: SRAM write enable.
- `mem_be`, out, 4: SRAM byte enables.
- `mem_addr`, out, ADDR_W-2: SRAM word address.
- `mem_wdata`, out, DATA_W: SRAM write data.
- `mem_rdata`, in, DATA_W: SRAM read data.
- `wr`, out, 1: store-completion trace pulse.
- `rd`, out, 1: load-completion trace pulse.
- `addr`, out, ADDR_W: trace byte address.
- `wr_data`, out, DATA_W: trace store data (lane-steered).
- `rd_data`, out, DATA_W: trace load data (extended).

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:** when `req_valid`=1, the request is checked.
  - Error case: misaligned (LH/SH/LHU with `addr[0]`≠0; LW/SW with `addr[1:0]`≠0), or illegal funct3 (3, 6, 7; or 4/5 with `req_we`=1).
    - `lsu_err` pulses 1 cycle (registered, next cycle).
    - No SRAM access, no `rsp_valid`, stay in IDLE.
    - `stall`=0.
  - Otherwise the request is latched and the FSM goes to ISSUE.
- **ISSUE:** `mem_en`=1 for exactly this cycle, with `mem_we`, `mem_be`, `mem_addr`=`addr[ADDR_W-1:2]` and `mem_wdata`.
  - Go to WAIT and load the counter with WAIT_CYC-1.
- **WAIT:** decrement the counter each cycle. At 0, sample `mem_rdata` and go to RESP.
- **RESP:** `rsp_valid`=1; the trace signals are valid. Go to IDLE. `req_valid` is ignored in RESP.
- **Lane steering for stores:**
  - SB: `be`=1<<`a[1:0]`, byte replicated ×4.
  - SH: `be`=3<<(2·`a[1]`), half replicated ×2.
  - SW: `be`=4'hF.
- **Loads:** `be`=4'hF. Extract the lane selected by `a[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend.
- **Stall:** `stall` = (IDLE & `req_valid` & no error) | ISSUE | WAIT.
- **Reset:** asserting `reset` in any state forces IDLE immediately. Every output goes to 0, `mem_en` included, so an in-flight access is abandoned and no `rsp_valid` follows.

## Timing
- Request accepted at cycle T.
  - `mem_en` is high at T+1.
  - `rsp_valid` is high at T+2+WAIT_CYC; with the default, T+3.
  - `stall` is high from T through T+1+WAIT_CYC, and low in the RESP cycle.
- Back-to-back: the next request can be accepted at T+3+WAIT_CYC, giving a throughput of 1 access per 3+WAIT_CYC cycles.
- `lsu_err` is asserted at T+1. A new request may be accepted at T+1.
- All outputs except `stall` are registered.
- `stall` is combinational from `req_valid` and state; it must not depend on `mem_rdata`.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_state_t` enum (IDLE/ISSUE/WAIT/RESP);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the `BE_*` constants.
- Sub-module `lsu_align` is purely combinational: it takes funct3, `addr[1:0]`, wdata and rdata, and produces `be`, steered wdata, extended rdata and `misaligned`. The top level holds the FSM, counter and registers.

## Test plan
- **SW then LW:** SW 0xDEADBEEF @0x010, then LW @0x010.
  - Store: `mem_be`=F, `mem_addr`=0x04.
  - Load: `rsp_rdata`=0xDEADBEEF at T+3.
  - `stall` is high for exactly 3 cycles per access.
- **SB then LB/LBU:** SB 0x80 @0x013, then LB and LBU @0x013.
  - Store: `mem_be`=4'b1000, `mem_wdata`=0x80808080.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- **SH then LH/LHU:** SH 0x8001 @0x016, then LH @0x016 returns 0xFFFF8001 and LHU returns 0x00008001.
  - Store: `be`=4'b1100.
- **Error cases:** LW @0x011 and funct3=3.
  - `lsu_err` pulses once each.
  - `mem_en` stays 0, no `rsp_valid`, `stall` stays 0.
- **Slow SRAM:** WAIT_CYC=4 with LW. `rsp_valid` arrives at T+6, and `stall` is high for 6 cycles.
- **Reset mid-access:** assert `reset` in WAIT.
  - All outputs are 0 within the same cycle.
  - After release, no `rsp_valid` appears, and a fresh LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 codes and byte-enable patterns.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B    = 4'b0001;
   localparam logic [3:0] BE_H    = 4'b0011;
   localparam logic [3:0] BE_W    = 4'b1111;

   // Unsigned variants exist only for loads.
   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = ~we;
         default:          f3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and alignment check.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata_lane,
   output logic [DATA_W-1:0] rdata_ext,
   output logic              misaligned
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rbyte      = 8'h00;
      rhalf      = 16'h0000;
      be         = BE_NONE;
      wdata_lane = '0;
      rdata_ext  = '0;
      misaligned = 1'b0;

      case (addr_lo)
         2'd0:    rbyte = rdata[7:0];
         2'd1:    rbyte = rdata[15:8];
         2'd2:    rbyte = rdata[23:16];
         default: rbyte = rdata[31:24];
      endcase
      rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B, F3_BU: begin
            be         = BE_B << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
         end
         F3_H, F3_HU: begin
            be         = BE_H << {addr_lo[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            misaligned = addr_lo[0];
         end
         F3_W: begin
            be         = BE_W;
            wdata_lane = wdata;
            rdata_ext  = rdata;
            misaligned = |addr_lo;
         end
         default: ;
      endcase

      // Loads always fetch the full word; the lane is picked on return.
      if (!we)
         be = BE_W;
   end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one access at a time to a synchronous single-port SRAM
// with WAIT_CYC read latency, stalling the datapath while in flight.
//
//   state | meaning
//   IDLE  | waiting for a request; errors are flagged here without leaving
//   ISSUE | SRAM enable cycle
//   WAIT  | counting down SRAM latency, samples read data at terminal count
//   RESP  | completion pulse and trace outputs valid
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int WAIT_CYC = 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              lsu_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wr,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

   lsu_state_t        state, state_nxt;
   logic [2:0]        cnt;
   logic              lat_we;
   logic [2:0]        lat_f3;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              sel_we;
   logic [2:0]        sel_f3;
   logic [1:0]        sel_lo;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata_lane;
   logic [DATA_W-1:0] rdata_ext;
   logic              misaligned;
   logic              bad;
   logic              accept;
   logic              req_err;

   // The aligner sees the live request in IDLE and the latched one afterwards.
   assign sel_we = (state == IDLE) ? req_we         : lat_we;
   assign sel_f3 = (state == IDLE) ? req_funct3     : lat_f3;
   assign sel_lo = (state == IDLE) ? req_addr[1:0]  : lat_addr[1:0];

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .we         (sel_we),
      .funct3     (sel_f3),
      .addr_lo    (sel_lo),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned)
   );

   assign bad = misaligned | ~f3_legal(req_funct3, req_we);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      req_err   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (bad) begin
                  req_err = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == 3'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gated by reset so every output reads 0 while reset is held.
   assign stall = ~reset & (accept | (state == ISSUE) | (state == WAIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         lat_we    <= 1'b0;
         lat_f3    <= 3'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= BE_NONE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         lsu_err   <= 1'b0;
         wr        <= 1'b0;
         rd        <= 1'b0;
         addr      <= '0;
         wr_data   <= '0;
         rd_data   <= '0;
      end else begin
         state     <= state_nxt;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= BE_NONE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         wr        <= 1'b0;
         rd        <= 1'b0;
         lsu_err   <= req_err;

         if (accept) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_we ? wdata_lane : '0;
            mem_en    <= 1'b1;
            mem_we    <= req_we;
            mem_be    <= be;
            mem_addr  <= req_addr[ADDR_W-1:2];
            mem_wdata <= req_we ? wdata_lane : '0;
         end

         if (state == ISSUE)
            cnt <= CNT_LOAD;
         else if (state == WAIT && cnt != 3'd0)
            cnt <= cnt - 3'd1;

         if (state == WAIT && cnt == 3'd0) begin
            rsp_valid <= 1'b1;
            wr        <= lat_we;
            rd        <= ~lat_we;
            addr      <= lat_addr;
            wr_data   <= lat_wdata;
            rsp_rdata <= lat_we ? '0 : rdata_ext;
            rd_data   <= lat_we ? '0 : rdata_ext;
         end
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: a fast (1 wait) and a slow (4 wait) instance, each with
// an SRAM model; expected events are queued by the driver and popped by a monitor.
module tb_lsu_unit;

   typedef struct {
      int          d;
      int          kind;   // 0 = SRAM access, 1 = response, 2 = error pulse
      logic        we;
      logic [3:0]  be;
      logic [6:0]  maddr;
      logic [31:0] wdat;
      logic [31:0] rdat;
      logic [8:0]  a;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic mem_clr;
   always #5 clk = ~clk;

   logic        req_valid  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [8:0]  req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        stall      [2];
   logic        rsp_valid  [2];
   logic [31:0] rsp_rdata  [2];
   logic        lsu_err    [2];
   logic        mem_en     [2];
   logic        mem_we     [2];
   logic [3:0]  mem_be     [2];
   logic [6:0]  mem_addr   [2];
   logic [31:0] mem_wdata  [2];
   logic [31:0] mem_rdata  [2];
   logic        wr         [2];
   logic        rd         [2];
   logic [8:0]  addr       [2];
   logic [31:0] wr_data    [2];
   logic [31:0] rd_data    [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 4;

      lsu_unit #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(L)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid[g]),
         .req_we     (req_we[g]),
         .req_funct3 (req_funct3[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .stall      (stall[g]),
         .rsp_valid  (rsp_valid[g]),
         .rsp_rdata  (rsp_rdata[g]),
         .lsu_err    (lsu_err[g]),
         .mem_en     (mem_en[g]),
         .mem_we     (mem_we[g]),
         .mem_be     (mem_be[g]),
         .mem_addr   (mem_addr[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_rdata  (mem_rdata[g]),
         .wr         (wr[g]),
         .rd         (rd[g]),
         .addr       (addr[g]),
         .wr_data    (wr_data[g]),
         .rd_data    (rd_data[g])
      );

      // SRAM: read data valid L cycles after the enable cycle, junk otherwise.
      logic [31:0] sram [128];
      logic [31:0] pipe [L];
      always @(posedge clk) begin
         if (mem_clr) begin
            for (int i = 0; i < 128; i++) sram[i] <= 32'h0;
         end else if (mem_en[g] && mem_we[g]) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[g][b]) sram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
         end
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? sram[mem_addr[g]] : $urandom;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[L-1];
   end

   logic [7:0] ref_mem [2][512];
   exp_t       exp_q [$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic outs_nonzero(input int d);
      return stall[d] | rsp_valid[d] | lsu_err[d] | mem_en[d] | mem_we[d] | wr[d] | rd[d] |
             (|rsp_rdata[d]) | (|mem_wdata[d]) | (|mem_be[d]) | (|mem_addr[d]) |
             (|addr[d]) | (|wr_data[d]) | (|rd_data[d]);
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   // Monitor: every event the DUT presents must match the head of the queue.
   int   mon_nev;
   int   mon_kind;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            mon_nev = int'(mem_en[d]) + int'(rsp_valid[d]) + int'(lsu_err[d]);
            if (mon_nev > 1) begin
               checks++;
               errors++;
               $display("FAIL event_overlap: dut %0d got %0d events in one cycle, expected 1", d, mon_nev);
            end else if (mon_nev == 1) begin
               mon_kind = mem_en[d] ? 0 : (rsp_valid[d] ? 1 : 2);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: dut %0d kind %0d with nothing expected", d, mon_kind);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("event_dut", 32'(d), 32'(mon_e.d));
                  chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                  if (mon_e.kind == mon_kind) begin
                     if (mon_kind == 0) begin
                        chk("mem_we", 32'(mem_we[d]), 32'(mon_e.we));
                        chk("mem_be", 32'(mem_be[d]), 32'(mon_e.be));
                        chk("mem_addr", 32'(mem_addr[d]), 32'(mon_e.maddr));
                        if (mon_e.we) chk("mem_wdata", mem_wdata[d], mon_e.wdat);
                     end else if (mon_kind == 1) begin
                        chk("rsp_rdata", rsp_rdata[d], mon_e.rdat);
                        chk("rd_data", rd_data[d], mon_e.rdat);
                        chk("trace_wr", 32'(wr[d]), 32'(mon_e.we));
                        chk("trace_rd", 32'(rd[d]), 32'(!mon_e.we));
                        chk("trace_addr", 32'(addr[d]), 32'(mon_e.a));
                        if (mon_e.we) chk("wr_data", wr_data[d], mon_e.wdat);
                     end
                  end
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 with req_valid low.
   task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd);
      int          n, w, ai, stall_n, men_k, rsp_k;
      logic        err;
      logic [31:0] val, lanes;
      exp_t        e;
      w   = (d == 0) ? 1 : 4;
      n   = size_of(f3);
      ai  = int'(a);
      err = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we))
            || (ai % n != 0);
      val = 32'h0;
      for (int i = 0; i < n; i++) val |= 32'(ref_mem[d][(ai + i) % 512]) << (8 * i);
      if (f3 < 3'd4 && n < 4 && val[8*n-1]) val |= ~((32'h1 << (8 * n)) - 32'h1);
      for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wd[8*(i % n) +: 8];

      e.d = d; e.we = we; e.a = a; e.maddr = a[8:2]; e.wdat = lanes;
      e.be = we ? 4'(((1 << n) - 1) << (ai % 4)) : 4'hF;
      e.rdat = we ? 32'h0 : val;
      if (err) begin
         e.kind = 2;
         exp_q.push_back(e);
      end else begin
         e.kind = 0;
         exp_q.push_back(e);
         e.kind = 1;
         exp_q.push_back(e);
         if (we) for (int i = 0; i < n; i++) ref_mem[d][ai + i] = wd[8*i +: 8];
      end

      req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
      req_addr[d] = a; req_wdata[d] = wd;
      if (err) begin
         @(negedge clk);
         chk("err_stall", 32'(stall[d]), 32'h0);
      end else begin
         stall_n = 0; men_k = -1; rsp_k = -1;
         for (int k = 0; k < 16 && rsp_k < 0; k++) begin
            @(negedge clk);
            if (stall[d]) stall_n++;
            if (mem_en[d] && men_k < 0) men_k = k;
            if (rsp_valid[d]) rsp_k = k;
         end
         chk("stall_cycles", 32'(stall_n), 32'(2 + w));
         chk("mem_en_latency", 32'(men_k), 32'h1);
         chk("rsp_latency", 32'(rsp_k), 32'(2 + w));
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [2:0]  f3;
      logic [8:0]  a;
      logic        we;
      int          sz, rsp_seen;
      exp_t        e;

      reset = 1'b1;
      mem_clr = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
         req_addr[d] = 9'd0; req_wdata[d] = 32'h0;
         for (int i = 0; i < 512; i++) ref_mem[d][i] = 8'h00;
      end
      idle(3);
      chk("reset_outputs_fast", 32'(outs_nonzero(0)), 32'h0);
      chk("reset_outputs_slow", 32'(outs_nonzero(1)), 32'h0);
      mem_clr = 1'b0;
      reset = 1'b0;
      idle(2);

      // Directed cases on the fast instance.
      do_req(0, 1'b1, 3'd2, 9'h010, 32'hDEADBEEF);
      do_req(0, 1'b0, 3'd2, 9'h010, 32'h0);
      do_req(0, 1'b1, 3'd0, 9'h013, 32'h00000080);
      do_req(0, 1'b0, 3'd0, 9'h013, 32'h0);
      do_req(0, 1'b0, 3'd4, 9'h013, 32'h0);
      do_req(0, 1'b1, 3'd1, 9'h016, 32'h00008001);
      do_req(0, 1'b0, 3'd1, 9'h016, 32'h0);
      do_req(0, 1'b0, 3'd5, 9'h016, 32'h0);
      do_req(0, 1'b0, 3'd2, 9'h011, 32'h0);
      do_req(0, 1'b0, 3'd3, 9'h000, 32'h0);
      do_req(0, 1'b1, 3'd4, 9'h000, 32'h0);
      do_req(0, 1'b0, 3'd2, 9'h010, 32'h0);
      idle(2);

      // Random traffic, including back-to-back and error requests.
      for (int it = 0; it < 200; it++) begin
         case ($urandom_range(0, 5))
            0:       f3 = 3'd0;
            1:       f3 = 3'd1;
            2:       f3 = 3'd2;
            3:       f3 = 3'd4;
            4:       f3 = 3'd5;
            default: f3 = 3'($urandom_range(0, 7));
         endcase
         we = 1'($urandom_range(0, 1));
         sz = size_of(f3);
         a  = 9'($urandom_range(0, 63));
         if ($urandom_range(0, 4) != 0) a = a & ~9'(sz - 1);
         do_req(0, we, f3, a, $urandom);
         idle($urandom_range(0, 2));
      end

      // Slow SRAM instance.
      do_req(1, 1'b1, 3'd2, 9'h020, 32'hCAFEF00D);
      do_req(1, 1'b0, 3'd2, 9'h020, 32'h0);
      do_req(1, 1'b0, 3'd0, 9'h023, 32'h0);

      // Reset while the slow instance is in WAIT: access abandoned.
      e.d = 1; e.kind = 0; e.we = 1'b0; e.be = 4'hF; e.maddr = 7'h08;
      e.wdat = 32'h0; e.rdat = 32'h0; e.a = 9'h020;
      exp_q.push_back(e);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2;
      req_addr[1] = 9'h020; req_wdata[1] = 32'h0;
      for (int k = 0; k < 4; k++) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_mid_outputs", 32'(outs_nonzero(1)), 32'h0);
      req_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rsp_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid[1]) rsp_seen++;
      end
      chk("no_rsp_after_reset", 32'(rsp_seen), 32'h0);
      @(posedge clk);
      #1;
      do_req(1, 1'b0, 3'd2, 9'h020, 32'h0);
      do_req(1, 1'b1, 3'd1, 9'h022, 32'h0000ABCD);
      do_req(1, 1'b0, 3'd1, 9'h022, 32'h0);

      idle(5);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
